// File: rtl/rx_block_sync.sv
// 66b receive block synchronizer: selects the 66-bit block window out of unaligned gearbox
// words using a slip pointer steered by a sync-header lock state machine.
module rx_block_sync #(
    parameter int unsigned LOCK_COUNT    = 64,
    parameter int unsigned INVALID_LIMIT = 16,
    parameter int unsigned SLIP_WAIT     = 2
) (
    input  logic        pcs_clk,
    input  logic        pcs_rst,
    input  logic [65:0] rx_raw_data,
    input  logic        rx_raw_valid,
    output logic [63:0] rx_pcs_data,
    output logic [1:0]  rx_pcs_header,
    output logic        rx_pcs_valid,
    output logic        block_lock,
    output logic [6:0]  slip_offset,
    output logic        slip_pulse
);

    localparam int unsigned ShW   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned InvW  = $clog2(INVALID_LIMIT + 1);
    localparam int unsigned WaitW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        StInit,
        StTest,
        StSlip,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic [ShW-1:0]    sh_cnt_q, sh_cnt_d;
    logic [InvW-1:0]   inv_cnt_q, inv_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic              lock_q, lock_d;
    logic [6:0]        offset_q, offset_d;
    logic              pulse_q, pulse_d;

    logic [65:0]       prev_q;
    logic              prev_loaded_q;
    logic [63:0]       data_q;
    logic [1:0]        header_q;
    logic              valid_q;

    logic [131:0]      concat;
    logic [65:0]       window;
    logic              hdr_bad;
    logic              word_ok;
    logic [ShW-1:0]    sh_inc;
    logic [InvW-1:0]   inv_inc;

    // The newest word sits above the previous one, so bit 0 of concat is the oldest bit.
    assign concat  = {rx_raw_data, prev_q};
    assign window  = 66'(concat >> offset_q);
    assign hdr_bad = ~(window[1] ^ window[0]);
    assign word_ok = rx_raw_valid & prev_loaded_q;
    assign sh_inc  = sh_cnt_q + 1'b1;
    assign inv_inc = inv_cnt_q + InvW'(hdr_bad);

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = lock_q;
        offset_d   = offset_q;
        pulse_d    = 1'b0;

        unique case (state_q)
            StInit: begin
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
                lock_d    = 1'b0;
                state_d   = StTest;
            end
            StTest: begin
                if (word_ok) begin
                    sh_cnt_d  = sh_inc;
                    inv_cnt_d = inv_inc;
                    if (hdr_bad && (!lock_q || (inv_inc == InvW'(INVALID_LIMIT)))) begin
                        // Slip bookkeeping is registered here so the pulse and the new
                        // offset are both visible during the SLIP cycle itself.
                        lock_d    = 1'b0;
                        offset_d  = (offset_q == 7'd65) ? 7'd0 : offset_q + 7'd1;
                        pulse_d   = 1'b1;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                        state_d   = StSlip;
                    end else if (sh_inc == ShW'(LOCK_COUNT)) begin
                        if (inv_inc == '0) begin
                            lock_d = 1'b1;
                        end
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end
                end
            end
            StSlip: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (SLIP_WAIT == 0) begin
                    state_d = StTest;
                end else if (rx_raw_valid) begin
                    if (wait_cnt_q == WaitW'(SLIP_WAIT - 1)) begin
                        state_d = StTest;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge pcs_clk or posedge pcs_rst) begin
        if (pcs_rst) begin
            state_q    <= StInit;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            lock_q     <= 1'b0;
            offset_q   <= 7'd0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            lock_q     <= lock_d;
            offset_q   <= offset_d;
            pulse_q    <= pulse_d;
        end
    end

    always_ff @(posedge pcs_clk or posedge pcs_rst) begin
        if (pcs_rst) begin
            prev_q        <= '0;
            prev_loaded_q <= 1'b0;
            data_q        <= '0;
            header_q      <= '0;
            valid_q       <= 1'b0;
        end else begin
            if (rx_raw_valid) begin
                prev_q        <= rx_raw_data;
                prev_loaded_q <= 1'b1;
                if (prev_loaded_q) begin
                    data_q   <= window[65:2];
                    header_q <= window[1:0];
                end
            end
            valid_q <= word_ok & lock_q;
        end
    end

    assign rx_pcs_data   = data_q;
    assign rx_pcs_header = header_q;
    assign rx_pcs_valid  = valid_q;
    assign block_lock    = lock_q;
    assign slip_offset   = offset_q;
    assign slip_pulse    = pulse_q;

endmodule

// File: tb/tb_rx_block_sync.sv
// Randomized bench for rx_block_sync: a bit-stream generator feeds the DUT and a behavioural
// model predicts every registered output, plus literal checks on lock/slip milestones.
module tb_rx_block_sync;

    localparam int LC = 64;
    localparam int IL = 16;
    localparam int SW = 2;

    logic        pcs_clk = 1'b0;
    logic        pcs_rst = 1'b1;
    logic [65:0] rx_raw_data = '0;
    logic        rx_raw_valid = 1'b0;
    logic [63:0] rx_pcs_data;
    logic [1:0]  rx_pcs_header;
    logic        rx_pcs_valid;
    logic        block_lock;
    logic [6:0]  slip_offset;
    logic        slip_pulse;

    rx_block_sync #(
        .LOCK_COUNT   (LC),
        .INVALID_LIMIT(IL),
        .SLIP_WAIT    (SW)
    ) dut (
        .pcs_clk      (pcs_clk),
        .pcs_rst      (pcs_rst),
        .rx_raw_data  (rx_raw_data),
        .rx_raw_valid (rx_raw_valid),
        .rx_pcs_data  (rx_pcs_data),
        .rx_pcs_header(rx_pcs_header),
        .rx_pcs_valid (rx_pcs_valid),
        .block_lock   (block_lock),
        .slip_offset  (slip_offset),
        .slip_pulse   (slip_pulse)
    );

    always #5 pcs_clk = ~pcs_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ignore-counters instead of states, window picked bit by bit.
    logic        m_init, m_loaded, m_lock, m_slipc, m_waiting;
    logic [65:0] m_prev;
    int          m_off, m_sh, m_inv, m_wait_left;
    logic [63:0] e_data;
    logic [1:0]  e_hdr;
    logic        e_valid, e_pulse;

    task automatic model_reset();
        m_init = 1'b1; m_loaded = 1'b0; m_lock = 1'b0; m_slipc = 1'b0; m_waiting = 1'b0;
        m_prev = '0; m_off = 0; m_sh = 0; m_inv = 0; m_wait_left = 0;
        e_data = '0; e_hdr = '0; e_valid = 1'b0; e_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [65:0] d);
        logic [131:0] c;
        logic [65:0]  w;
        logic         bad;
        c = {d, m_prev};
        for (int i = 0; i < 66; i++) w[i] = c[m_off + i];
        bad = (w[1:0] == 2'b00) || (w[1:0] == 2'b11);
        e_pulse = 1'b0;
        e_valid = v && m_loaded && m_lock;
        if (v && m_loaded) begin
            e_data = w[65:2];
            e_hdr  = w[1:0];
        end
        if (m_init) begin
            m_init = 1'b0;
        end else if (m_slipc) begin
            m_slipc = 1'b0;
            m_waiting = 1'b1;
            m_wait_left = SW;
        end else if (m_waiting) begin
            if (m_wait_left == 0) m_waiting = 1'b0;
            else if (v) begin
                m_wait_left--;
                if (m_wait_left == 0) m_waiting = 1'b0;
            end
        end else if (v && m_loaded) begin
            m_sh++;
            if (bad) m_inv++;
            if (bad && (!m_lock || m_inv == IL)) begin
                m_lock = 1'b0;
                m_off = (m_off + 1) % 66;
                e_pulse = 1'b1;
                m_sh = 0; m_inv = 0;
                m_slipc = 1'b1;
            end else if (m_sh == LC) begin
                if (m_inv == 0) m_lock = 1'b1;
                m_sh = 0; m_inv = 0;
            end
        end
        if (v) begin
            m_prev = d;
            m_loaded = 1'b1;
        end
    endtask

    always @(negedge pcs_clk) begin
        if (chk_en && !pcs_rst) begin
            check("data", 66'(rx_pcs_data), 66'(e_data));
            check("header", 66'(rx_pcs_header), 66'(e_hdr));
            check("valid", 66'(rx_pcs_valid), 66'(e_valid));
            check("lock", 66'(block_lock), 66'(m_lock));
            check("offset", 66'(slip_offset), 66'(m_off));
            check("pulse", 66'(slip_pulse), 66'(e_pulse));
        end
    end

    // Serial stream generator: k filler bits, then back-to-back 66b blocks, bit 0 first.
    logic [197:0] g_buf;
    int           g_bits;

    task automatic gen_start(input int k);
        g_buf = '0;
        for (int i = 0; i < k; i++) g_buf[i] = 1'($urandom_range(0, 1));
        g_bits = k;
    endtask

    task automatic gen_word(output logic [65:0] w);
        logic [65:0] blk;
        logic [1:0]  hdr;
        while (g_bits < 66) begin
            hdr = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            blk = {$urandom, $urandom, hdr};
            g_buf = g_buf | (198'(blk) << g_bits);
            g_bits += 66;
        end
        w = g_buf[65:0];
        g_buf = g_buf >> 66;
        g_bits -= 66;
    endtask

    task automatic cycle(input logic v, input logic [65:0] d);
        rx_raw_valid = v;
        rx_raw_data  = d;
        @(posedge pcs_clk);
        model_step(v, d);
        @(negedge pcs_clk);
    endtask

    task automatic do_reset();
        pcs_rst = 1'b1;
        rx_raw_valid = 1'b0;
        rx_raw_data = '0;
        model_reset();
        repeat (2) @(negedge pcs_clk);
        pcs_rst = 1'b0;
    endtask

    // Runs the generator stream until lock; vpct is the percentage of valid cycles.
    task automatic acquire(input int vpct, output int pulses, output logic ok);
        logic [65:0] w;
        logic        v;
        pulses = 0;
        ok = 1'b0;
        for (int n = 0; n < 4000 && !ok; n++) begin
            v = ($urandom_range(0, 99) < vpct);
            if (v) gen_word(w);
            else w = {$urandom, $urandom, 2'($urandom)};
            cycle(v, w);
            if (slip_pulse) pulses++;
            if (block_lock) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL acquire_timeout: lock=0, want lock=1");
        end
    endtask

    task automatic wait_window_start();
        logic [65:0] w;
        for (int n = 0; n < 200 && m_sh != 1; n++) begin
            gen_word(w);
            cycle(1'b1, w);
        end
        check("window_start", 66'(m_sh), 66'(1));
    endtask

    logic [65:0] w;
    int          pulses;
    int          nvalid;
    int          k;
    logic        ok;
    logic        seen;

    initial begin
        model_reset();
        repeat (2) @(negedge pcs_clk);
        check("rst_data", 66'(rx_pcs_data), 66'(0));
        check("rst_header", 66'(rx_pcs_header), 66'(0));
        check("rst_valid", 66'(rx_pcs_valid), 66'(0));
        check("rst_lock", 66'(block_lock), 66'(0));
        check("rst_offset", 66'(slip_offset), 66'(0));
        check("rst_pulse", 66'(slip_pulse), 66'(0));
        pcs_rst = 1'b0;
        chk_en = 1'b1;

        // Aligned stream: lock after exactly 1 load + 64 evaluations, no slips.
        gen_start(0);
        pulses = 0;
        for (int n = 1; n <= 65; n++) begin
            gen_word(w);
            cycle(1'b1, w);
            if (slip_pulse) pulses++;
            if (n == 64) check("lock_at_64", 66'(block_lock), 66'(0));
            if (n == 65) check("lock_at_65", 66'(block_lock), 66'(1));
        end
        for (int n = 0; n < 100; n++) begin
            gen_word(w);
            cycle(1'b1, w);
            if (slip_pulse) pulses++;
        end
        check("aligned_no_slip", 66'(pulses), 66'(0));
        check("aligned_pcs_valid", 66'(rx_pcs_valid), 66'(1));
        check("aligned_hdr_good", 66'(rx_pcs_header == 2'b01 || rx_pcs_header == 2'b10),
              66'(1));

        // 15 bad headers inside one window keep lock.
        wait_window_start();
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            gen_word(w);
            w[1:0] = 2'b11;
            cycle(1'b1, w);
            if (slip_pulse) pulses++;
        end
        for (int n = 0; n < 70; n++) begin
            gen_word(w);
            cycle(1'b1, w);
            if (slip_pulse) pulses++;
        end
        check("bad15_lock", 66'(block_lock), 66'(1));
        check("bad15_no_slip", 66'(pulses), 66'(0));

        // 16 bad headers inside one window drop lock and slip to offset 1.
        wait_window_start();
        for (int n = 0; n < 16; n++) begin
            gen_word(w);
            w[1:0] = 2'b11;
            cycle(1'b1, w);
        end
        check("bad16_lock_before", 66'(block_lock), 66'(1));
        gen_word(w);
        cycle(1'b1, w);
        check("bad16_lock_after", 66'(block_lock), 66'(0));
        check("bad16_pulse", 66'(slip_pulse), 66'(1));
        check("bad16_offset", 66'(slip_offset), 66'(1));

        // True alignment at 65, then a forced slip wraps the pointer to 0.
        do_reset();
        gen_start(65);
        acquire(100, pulses, ok);
        check("off65_pulses", 66'(pulses), 66'(65));
        check("off65_offset", 66'(slip_offset), 66'(65));
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            cycle(1'b1, {66{1'b1}});
            if (slip_pulse) seen = 1'b1;
        end
        check("wrap_seen", 66'(seen), 66'(1));
        check("wrap_offset", 66'(slip_offset), 66'(0));
        check("wrap_lock", 66'(block_lock), 66'(0));

        // Valid toggling every cycle: lock after 64 evaluations, never valid after a gap.
        do_reset();
        gen_start(0);
        nvalid = 0;
        for (int n = 0; n < 140; n++) begin
            if ((n % 2) == 0) begin
                gen_word(w);
                cycle(1'b1, w);
                nvalid++;
                if (nvalid == 64) check("toggle_lock_64", 66'(block_lock), 66'(0));
                if (nvalid == 65) check("toggle_lock_65", 66'(block_lock), 66'(1));
            end else begin
                cycle(1'b0, {$urandom, $urandom, 2'($urandom)});
                check("toggle_gap_valid", 66'(rx_pcs_valid), 66'(0));
            end
        end

        // Offset 17 acquisition, mid-lock async reset, then reacquisition.
        do_reset();
        gen_start(17);
        acquire(100, pulses, ok);
        check("off17_pulses", 66'(pulses), 66'(17));
        check("off17_offset", 66'(slip_offset), 66'(17));
        for (int n = 0; n < 80; n++) begin
            gen_word(w);
            cycle(1'b1, w);
        end
        check("off17_still_locked", 66'(block_lock), 66'(1));
        #2 pcs_rst = 1'b1;
        #1;
        check("mid_rst_data", 66'(rx_pcs_data), 66'(0));
        check("mid_rst_header", 66'(rx_pcs_header), 66'(0));
        check("mid_rst_valid", 66'(rx_pcs_valid), 66'(0));
        check("mid_rst_lock", 66'(block_lock), 66'(0));
        check("mid_rst_offset", 66'(slip_offset), 66'(0));
        check("mid_rst_pulse", 66'(slip_pulse), 66'(0));
        model_reset();
        @(negedge pcs_clk);
        pcs_rst = 1'b0;
        gen_start(17);
        gen_word(w);
        cycle(1'b1, w);
        check("first_word_valid", 66'(rx_pcs_valid), 66'(0));
        check("first_word_data", 66'(rx_pcs_data), 66'(0));
        acquire(100, pulses, ok);
        check("reacq_pulses", 66'(pulses), 66'(17));
        check("reacq_offset", 66'(slip_offset), 66'(17));

        // Random offset with random valid gaps, then random garbage words.
        do_reset();
        k = $urandom_range(1, 64);
        gen_start(k);
        acquire(70, pulses, ok);
        check("rand_pulses", 66'(pulses), 66'(k));
        check("rand_offset", 66'(slip_offset), 66'(k));
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 75) begin
                gen_word(w);
                if ($urandom_range(0, 99) < 6) w = {$urandom, $urandom, 2'($urandom)};
                cycle(1'b1, w);
            end else begin
                cycle(1'b0, {$urandom, $urandom, 2'($urandom)});
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
